// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter at 0x800-0x80F: a byte FIFO fed by core
// stores, drained by a bit-serial shifter with a programmable clocks-per-bit divisor.
module mmio_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        we,
  output logic [31:0] data_out,
  output logic        sel,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_n;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wptr, rptr;
  logic [CW-1:0]          count;
  logic                   overflow;
  logic [DIV_WIDTH-1:0]   div, div_l, cyc;
  logic [2:0]             bitn;
  logic [7:0]             shift;
  logic                   prev_wr;
  logic [31:0]            prev_addr;
  logic                   wr, fire, push_req, push, pop;
  logic                   full, empty, busy, bit_end;
  logic [1:0]             reg_sel;
  logic                   unused_ok;

  assign sel      = (address[31:4] == 28'h0000080);
  assign wr       = sel & we;
  // A write held across cycles at one address acts only on its first cycle.
  assign fire     = wr & ~(prev_wr & (prev_addr == address));
  assign reg_sel  = address[3:2];
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign push_req = fire & (reg_sel == 2'd0);
  assign push     = push_req & ~full;
  assign bit_end  = (cyc == div_l - DIV_WIDTH'(1));
  assign unused_ok = &{1'b0, address[1:0], data_in};

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx      = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (bit_end && bitn == 3'd7) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      case (reg_sel)
        2'd1:    data_out = {28'b0, overflow, busy, empty, full};
        2'd2:    data_out[DIV_WIDTH-1:0] = div;
        2'd3:    data_out[CW-1:0] = count;
        default: data_out = '0;
      endcase
    end
  end

  // Control state: FSM, bit timing, FIFO pointers and registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cyc       <= '0;
      bitn      <= '0;
      div_l     <= DIV_WIDTH'(1);
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      div       <= DIV_WIDTH'(DEFAULT_DIV);
      prev_wr   <= 1'b0;
      prev_addr <= '0;
    end else begin
      state     <= state_n;
      prev_wr   <= wr;
      prev_addr <= address;
      if (pop) begin
        div_l <= (div == '0) ? DIV_WIDTH'(1) : div;
        cyc   <= '0;
        bitn  <= '0;
        rptr  <= rptr + AW'(1);
      end else if (state != IDLE) begin
        if (bit_end) begin
          cyc <= '0;
          if (state == DATA) bitn <= bitn + 3'd1;
        end else begin
          cyc <= cyc + DIV_WIDTH'(1);
        end
      end
      if (push) wptr <= wptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && full) overflow <= 1'b1;
      else if (fire && reg_sel == 2'd1 && data_in[3]) overflow <= 1'b0;
      if (fire && reg_sel == 2'd2) div <= data_in[DIV_WIDTH-1:0];
    end
  end

  // Datapath: FIFO storage and shift register.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data_in[7:0];
    if (pop) shift <= mem[rptr];
    else if (state == DATA && bit_end) shift <= {1'b0, shift[7:1]};
  end

endmodule
